// File: rtl/jtframe_layer_colmix.sv
// Layer priority mixer with CPU-writable 15-bit palette, driving blanked 5-bit RGB.
// Latency: 3 pxl_cen ticks from lyr_pxl to RGB; CPU read data 1 clk after address.
// Backpressure: none; video stages hold when pxl_cen is low, CPU port is always live.
// Optional: define JTFRAME_COLMIX_BRIGHT_EN to add the bright[3:0] output scaler.
module jtframe_layer_colmix #(
    parameter int LAYERS = 4,
    parameter int PXLW   = 9,
    parameter int TRANSW = 4,
    parameter int BGIDX  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    input  logic [LAYERS*PXLW-1:0] lyr_pxl,
    input  logic [LAYERS-1:0]      gfx_en,
    input  logic [PXLW:0]          cpu_addr,
    input  logic [7:0]             cpu_dout,
    input  logic                   cpu_rnw,
    input  logic                   pal_cs,
`ifdef JTFRAME_COLMIX_BRIGHT_EN
    input  logic [3:0]             bright,
`endif
    output logic [7:0]             cpu_din,
    output logic [4:0]             red,
    output logic [4:0]             green,
    output logic [4:0]             blue,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly
);

    localparam int              DEPTH = 1 << PXLW;
    localparam logic [PXLW-1:0] TMASK = PXLW'((1 << TRANSW) - 1);
    localparam logic [PXLW-1:0] BG    = PXLW'(BGIDX);

    // Palette banks: LO holds G[2:0],B; HI holds x,R,G[4:3]. Not reset.
    logic [7:0] pal_lo_q [DEPTH];
    logic [7:0] pal_hi_q [DEPTH];

    logic [PXLW-1:0] cpu_idx;
    logic            pal_we;
    assign cpu_idx = cpu_addr[PXLW:1];
    assign pal_we  = pal_cs & ~cpu_rnw;

    logic [7:0]      cpu_din_d,  cpu_din_q;
    logic [PXLW-1:0] win_idx;
    logic [PXLW-1:0] pal_idx_d,  pal_idx_q;
    logic [14:0]     col_d,      col_q;
    logic [2:0]      lhbl_sr_d,  lhbl_sr_q;
    logic [2:0]      lvbl_sr_d,  lvbl_sr_q;
    logic [4:0]      red_d,      red_q;
    logic [4:0]      green_d,    green_q;
    logic [4:0]      blue_d,     blue_q;
    logic [4:0]      dec_r, dec_g, dec_b;
    logic            video_on;

`ifdef JTFRAME_COLMIX_BRIGHT_EN
    // c*(bright+1)>>4 with a 9-bit product; bright=15 is identity.
    function automatic logic [4:0] scale(input logic [4:0] c, input logic [3:0] b);
        logic [8:0] m;
        m = {4'd0, c} * {4'd0, {1'b0, b} + 5'd1};
        return 5'(m >> 4);
    endfunction
`endif

    // CPU writes land in the bank picked by the byte select bit
    always_ff @(posedge clk) begin
        if (pal_we) begin
            if (cpu_addr[0]) pal_hi_q[cpu_idx] <= cpu_dout;
            else             pal_lo_q[cpu_idx] <= cpu_dout;
        end
    end

    // CPU read-back: write-first, zero when not selected
    always_comb begin
        cpu_din_d = 8'd0;
        if (pal_cs) begin
            if (!cpu_rnw)        cpu_din_d = cpu_dout;
            else if (cpu_addr[0]) cpu_din_d = pal_hi_q[cpu_idx];
            else                 cpu_din_d = pal_lo_q[cpu_idx];
        end
    end

    // S0 priority: the highest-numbered opaque enabled layer wins, else background
    always_comb begin
        win_idx = BG;
        for (int n = 0; n < LAYERS; n++) begin
            if (gfx_en[n] && ((lyr_pxl[n*PXLW +: PXLW] & TMASK) != '0))
                win_idx = lyr_pxl[n*PXLW +: PXLW];
        end
    end

    // S2 colour decode, optionally scaled by brightness
    always_comb begin
`ifdef JTFRAME_COLMIX_BRIGHT_EN
        dec_r = scale(col_q[14:10], bright);
        dec_g = scale(col_q[9:5],   bright);
        dec_b = scale(col_q[4:0],   bright);
`else
        dec_r = col_q[14:10];
        dec_g = col_q[9:5];
        dec_b = col_q[4:0];
`endif
    end

    // Video pipeline next-state: every stage advances only on pxl_cen.
    // The palette read uses the array's pre-edge contents, so a same-cycle
    // CPU write to that entry is seen by the video side one tick later.
    always_comb begin
        pal_idx_d = pal_idx_q;
        col_d     = col_q;
        lhbl_sr_d = lhbl_sr_q;
        lvbl_sr_d = lvbl_sr_q;
        red_d     = red_q;
        green_d   = green_q;
        blue_d    = blue_q;
        video_on  = lhbl_sr_q[1] & lvbl_sr_q[1];
        if (pxl_cen) begin
            pal_idx_d = win_idx;
            col_d     = {pal_hi_q[pal_idx_q][6:0], pal_lo_q[pal_idx_q]};
            lhbl_sr_d = {lhbl_sr_q[1:0], LHBL};
            lvbl_sr_d = {lvbl_sr_q[1:0], LVBL};
            red_d     = video_on ? dec_r : 5'd0;
            green_d   = video_on ? dec_g : 5'd0;
            blue_d    = video_on ? dec_b : 5'd0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cpu_din_q <= 8'd0;
            pal_idx_q <= '0;
            col_q     <= 15'd0;
            lhbl_sr_q <= 3'd0;
            lvbl_sr_q <= 3'd0;
            red_q     <= 5'd0;
            green_q   <= 5'd0;
            blue_q    <= 5'd0;
        end else begin
            cpu_din_q <= cpu_din_d;
            pal_idx_q <= pal_idx_d;
            col_q     <= col_d;
            lhbl_sr_q <= lhbl_sr_d;
            lvbl_sr_q <= lvbl_sr_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
        end
    end

    assign cpu_din  = cpu_din_q;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign LHBL_dly = lhbl_sr_q[2];
    assign LVBL_dly = lvbl_sr_q[2];

endmodule

// File: tb/tb_jtframe_layer_colmix.sv
// Directed bench for jtframe_layer_colmix with default parameters.
module tb_jtframe_layer_colmix;

    logic        clk = 1'b0;
    logic        rst_n, pxl_cen, LHBL, LVBL;
    logic [35:0] lyr_pxl;
    logic [3:0]  gfx_en;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_dout, cpu_din;
    logic        cpu_rnw, pal_cs;
    logic [4:0]  red, green, blue;
    logic        LHBL_dly, LVBL_dly;

    int n_assert = 0;
    int n_fail   = 0;

    jtframe_layer_colmix dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
        .lyr_pxl(lyr_pxl), .gfx_en(gfx_en), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_rnw(cpu_rnw), .pal_cs(pal_cs), .cpu_din(cpu_din),
        .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
        check({tag, "_r"}, {11'd0, red},   {11'd0, r});
        check({tag, "_g"}, {11'd0, green}, {11'd0, g});
        check({tag, "_b"}, {11'd0, blue},  {11'd0, b});
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_addr = a; cpu_dout = d;
        tick();
        pal_cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic cpu_read(input logic [9:0] a, output logic [7:0] d);
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
        tick();
        d = cpu_din;
        pal_cs = 1'b0;
    endtask

    function automatic logic [35:0] px(input logic [8:0] l3, input logic [8:0] l2,
                                       input logic [8:0] l1, input logic [8:0] l0);
        return {l3, l2, l1, l0};
    endfunction

    logic [7:0] rd;

    initial begin
        rst_n = 1'b0; pxl_cen = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
        lyr_pxl = '0; gfx_en = 4'hF; cpu_addr = '0; cpu_dout = '0;
        cpu_rnw = 1'b1; pal_cs = 1'b0;
        ticks(2);
        check("rst_red", {11'd0, red}, 16'd0);
        check("rst_green", {11'd0, green}, 16'd0);
        check("rst_blue", {11'd0, blue}, 16'd0);
        check("rst_cpu_din", {8'd0, cpu_din}, 16'd0);
        check("rst_lhbl_dly", {15'd0, LHBL_dly}, 16'd0);
        check("rst_lvbl_dly", {15'd0, LVBL_dly}, 16'd0);
        rst_n = 1'b1;

        // Palette write then read: entry 1 = 0x7C1F
        cpu_write(10'h002, 8'h1F);
        cpu_write(10'h003, 8'h7C);
        cpu_read(10'h002, rd);
        check("rd_lo", {8'd0, rd}, 16'h001F);
        cpu_read(10'h003, rd);
        check("rd_hi", {8'd0, rd}, 16'h007C);
        tick();
        check("din_idle_zero", {8'd0, cpu_din}, 16'd0);
        cpu_write(10'h004, 8'hAA);
        check("write_first", {8'd0, cpu_din}, 16'h00AA);

        // entry 0 = 0x001F (background), entry 0xF2 = 0x03E0
        cpu_write(10'h000, 8'h1F);
        cpu_write(10'h001, 8'h00);
        cpu_write(10'h1E4, 8'hE0);
        cpu_write(10'h1E5, 8'h03);
        ticks(3);
        check_rgb("bg_before", 5'd0, 5'd0, 5'd31);

        // Single opaque layer, exactly 3 ticks of latency
        lyr_pxl = px(9'h0, 9'h0, 9'h0, 9'h001);
        ticks(2);
        check("lat_tick2_red", {11'd0, red}, 16'd0);
        tick();
        check_rgb("single", 5'd31, 5'd0, 5'd31);

        // Priority: layer 3 beats layer 0, then disable layer 3
        lyr_pxl = px(9'h0F2, 9'h0, 9'h0, 9'h001);
        ticks(3);
        check_rgb("prio", 5'd0, 5'd31, 5'd0);
        gfx_en = 4'b0111;
        ticks(3);
        check_rgb("prio_dis", 5'd31, 5'd0, 5'd31);

        // Transparency: low nibble zero on every layer selects background
        gfx_en = 4'hF;
        lyr_pxl = px(9'h010, 9'h010, 9'h010, 9'h010);
        ticks(3);
        check_rgb("transp", 5'd0, 5'd0, 5'd31);

        // Blanking: LHBL low for two ticks with an opaque pixel
        lyr_pxl = px(9'h0, 9'h0, 9'h0, 9'h001);
        ticks(3);
        LHBL = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 1) LHBL = 1'b1;
            check($sformatf("blank_red_%0d", i), {11'd0, red},
                  (i == 2 || i == 3) ? 16'd0 : 16'd31);
            check($sformatf("blank_dly_%0d", i), {15'd0, LHBL_dly},
                  (i == 2 || i == 3) ? 16'd0 : 16'd1);
        end

        // Hold with pxl_cen low; CPU port still answers
        pxl_cen = 1'b0;
        lyr_pxl = px(9'h010, 9'h010, 9'h010, 9'h010);
        LHBL = 1'b0;
        ticks(4);
        check("hold_red", {11'd0, red}, 16'd31);
        check("hold_lhbl_dly", {15'd0, LHBL_dly}, 16'd1);
        cpu_read(10'h002, rd);
        check("hold_cpu_rd", {8'd0, rd}, 16'h001F);
        pxl_cen = 1'b1;
        LHBL = 1'b1;

        // Collision: write entry 1 high byte while S1 reads entry 1
        ticks(3);
        lyr_pxl = px(9'h0, 9'h0, 9'h0, 9'h001);
        tick();
        cpu_write(10'h003, 8'h03);
        tick();
        check("coll_old_red", {11'd0, red}, 16'd31);
        check("coll_old_green", {11'd0, green}, 16'd0);
        tick();
        check_rgb("coll_new", 5'd0, 5'd24, 5'd31);

        // Mid-frame reset with a pending CPU read; palette survives
        rst_n = 1'b0;
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = 10'h002;
        tick();
        check_rgb("mid_rst", 5'd0, 5'd0, 5'd0);
        check("mid_rst_din", {8'd0, cpu_din}, 16'd0);
        check("mid_rst_lhbl", {15'd0, LHBL_dly}, 16'd0);
        check("mid_rst_lvbl", {15'd0, LVBL_dly}, 16'd0);
        rst_n = 1'b1;
        pal_cs = 1'b0;
        ticks(2);
        check("post_rst_t2_green", {11'd0, green}, 16'd0);
        check("post_rst_t2_lhbl", {15'd0, LHBL_dly}, 16'd0);
        tick();
        check_rgb("post_rst_t3", 5'd0, 5'd24, 5'd31);
        check("post_rst_t3_lhbl", {15'd0, LHBL_dly}, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_layer_colmix.md
Name: jtframe_layer_colmix

Overview:
- Parametrised colour mixer for Seta-class (X1-007 style) boards.
- Accepts indexed pixels from several graphics layers and picks the visible one by fixed priority.
- Looks the winner up in an internal CPU-writable 15-bit palette RAM and drives blanked 5-bit RGB to the video output.
- Sits between the tile/sprite engines and the frame's video output, with the palette mapped into main-CPU space.

Parameters:
- LAYERS, 4, number of layer pixel inputs (1..8); layer LAYERS-1 has the highest priority.
- PXLW, 9, palette index width; the palette holds 2^PXLW colours.
- TRANSW, 4, number of low index bits that must be zero for a pixel to be transparent.
- BGIDX, 0, palette index shown when every layer is transparent or disabled.

Ports:
- clk  in  1  system clock; the CPU side and the video side both run on it.
- rst_n  in  1  synchronous, active-low reset.
- pxl_cen  in  1  pixel clock enable; every video pipeline stage advances only when it is high.
- LHBL  in  1  horizontal blank, active low.
- LVBL  in  1  vertical blank, active low.
- lyr_pxl  in  LAYERS*PXLW  layer pixels; layer n occupies bits [n*PXLW +: PXLW].
- gfx_en  in  LAYERS  per-layer enable; 0 forces that layer transparent.
- cpu_addr  in  PXLW+1  byte address; bit 0 selects 0 = low byte, 1 = high byte.
- cpu_dout  in  8  CPU write data.
- cpu_rnw  in  1  1 = read, 0 = write.
- pal_cs  in  1  palette chip select.
- cpu_din  out  8  CPU read data.
- red  out  5  red output.
- green  out  5  green output.
- blue  out  5  blue output.
- LHBL_dly  out  1  LHBL delayed to line up with RGB.
- LVBL_dly  out  1  LVBL delayed to line up with RGB.

Behaviour:
- Palette storage:
  - Two byte-wide banks, LO and HI, each 2^PXLW deep. Each bank is dual-ported: one port for the CPU, one for video.
  - Colour word = {HI,LO}, laid out as x,R[14:10],G[9:5],B[4:0].
  - A CPU write happens on any clk edge where pal_cs=1 and cpu_rnw=0. It goes to bank cpu_addr[0] at index cpu_addr[PXLW:1].
- CPU reads:
  - cpu_din is registered; it is valid the cycle after the address is presented.
  - cpu_din is 0 while pal_cs=0.
  - The CPU port is write-first: reading back the address just written returns the new data.
- Video pipeline (each stage advances only on a clk edge with pxl_cen=1):
  - S0: a layer is opaque when its enable bit is 1 and its index[TRANSW-1:0] is non-zero. Select the highest-numbered opaque layer. If no layer is opaque, select BGIDX. Register the result as pal_idx.
  - S1: read LO[pal_idx] and HI[pal_idx] together. The video port is read-first, so a CPU write to the same entry in the same cycle shows the old colour.
  - S2: decode the colour. If the delayed LHBL & LVBL is 0, register RGB = 0; otherwise register RGB = the decoded colour.
- Latency and alignment:
  - Total latency is 3 pxl_cen ticks from lyr_pxl to RGB.
  - LHBL_dly and LVBL_dly use a 3-stage shift register clocked on pxl_cen, so they stay aligned with RGB.
- Holding:
  - With pxl_cen held low, every stage and every output holds.
  - The CPU port stays fully operational while pxl_cen is low.
- Reset (rst_n=0 at a clk edge):
  - red, green, blue, cpu_din, LHBL_dly and LVBL_dly all go to 0.
  - All pipeline registers clear.
  - Palette RAM contents are not cleared.
  - A reset in the middle of a line simply blanks output until three valid ticks have passed after release.
- Parameter limits:
  - LAYERS=1 is legal and reduces S0 to a transparency test.
  - TRANSW must be less than or equal to PXLW.

Optional Feature:
- Macro: JTFRAME_COLMIX_BRIGHT_EN.
- Defined:
  - Adds input port bright[3:0].
  - S2 outputs each channel as (c*(bright+1))>>4, computed with a 9-bit intermediate and truncated.
  - bright=15 gives the unscaled colour; bright=0 gives c>>4.
  - Latency stays 3 ticks.
- Undefined:
  - No bright port.
  - Output is the unscaled colour.

Test Plan:
- Palette write then read:
  - Stimulus: write 0x1F to address 0x002 and 0x7C to address 0x003, then read both addresses.
  - Response: reads return 0x1F and 0x7C one cycle after each address is presented.
- Single opaque layer:
  - Setup: entry 1 = 0x7C1F; layer 0 pixel = 0x001; other layers 0; blanks high; pxl_cen every cycle.
  - Response: RGB = (31,0,31) exactly 3 ticks later.
- Priority:
  - Setup: layer 0 = 0x001, layer 3 = 0x0F2; entry 0xF2 = 0x03E0.
  - Response: green=31, red=0, blue=0.
  - Then clear gfx_en[3]: output reverts to entry 1's colour.
- Transparency and background:
  - Setup: all layers = 0x010 with low nibble 0; BGIDX=0; entry 0 = 0x001F.
  - Response: blue=31, red=0, green=0.
- Blanking:
  - Stimulus: pulse LHBL low for 2 ticks with an opaque pixel present.
  - Response: RGB = 0 for exactly those 2 ticks, 3 ticks later; LHBL_dly low over the same window.
- Reset and collision:
  - Reset: assert rst_n=0 mid-frame; all outputs 0 at the next edge.
  - Collision: a CPU write to the entry S1 is reading in the same cycle outputs the old colour that tick and the new colour on the next identical pixel.
